// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: register addresses and edge-type selectors shared by the input PIO
package nios_pio_pkg;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_pio_debounce_bit.sv
// nios_pio_debounce_bit: one input bit through a synchroniser and optional debounce counter
module nios_pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= 1'b0;
      else q <= sync;
  end else begin : g_debounce
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    logic [CNT_WIDTH-1:0] cnt;
    // cnt counts consecutive cycles that sync has disagreed with q
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (sync == q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        q   <= sync;
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
  end
endmodule

// File: rtl/nios_pio_in_capture.sv
// nios_pio_in_capture: Avalon-MM input PIO with synchroniser, debounce, sticky edge capture and irq
module nios_pio_in_capture
  import nios_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);
  logic [DATA_WIDTH-1:0] stable, prev, mask, capture, edges, clr, wd, capture_nx, mask_nx;
  logic [31:0]           rd_nx;
  logic                  wr;
  logic                  unused_ok;
  assign unused_ok = &{1'b0, writedata};
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    nios_pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (in_port[i]),
      .q      (stable[i])
    );
  end
  // a new edge overrides a same-cycle clear so no event is ever lost
  always_comb begin
    wr         = chipselect & ~write_n;
    wd         = writedata[DATA_WIDTH-1:0];
    edges      = EDGE_TYPE == EDGE_RISE ? stable & ~prev :
                 EDGE_TYPE == EDGE_FALL ? ~stable & prev : stable ^ prev;
    clr        = (wr && address == PIO_ADDR_EDGE) ? wd : '0;
    capture_nx = (capture & ~clr) | edges;
    mask_nx    = (wr && address == PIO_ADDR_MASK) ? wd : mask;
    rd_nx      = address == PIO_ADDR_DATA ? 32'(stable) :
                 address == PIO_ADDR_MASK ? 32'(mask) :
                 address == PIO_ADDR_EDGE ? 32'(capture) : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev     <= '0;
      mask     <= '0;
      capture  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= stable;
      mask     <= mask_nx;
      capture  <= capture_nx;
      readdata <= rd_nx;
      irq      <= |(capture & mask);
    end
endmodule
